// File: rtl/matrix_result_serializer.sv
// ============================================================================
//  Module   : matrix_result_serializer
//  Brief    : Snapshots a flattened 5x5 matrix and streams its r x c
//             sub-matrix out row-major, one element per valid/ready transfer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_result_serializer #(
    parameter int DATA_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [2:0]            r_in,
    input  logic [2:0]            c_in,
    input  logic [DATA_WIDTH-1:0] data_in_0,  data_in_1,  data_in_2,  data_in_3,  data_in_4,
    input  logic [DATA_WIDTH-1:0] data_in_5,  data_in_6,  data_in_7,  data_in_8,  data_in_9,
    input  logic [DATA_WIDTH-1:0] data_in_10, data_in_11, data_in_12, data_in_13, data_in_14,
    input  logic [DATA_WIDTH-1:0] data_in_15, data_in_16, data_in_17, data_in_18, data_in_19,
    input  logic [DATA_WIDTH-1:0] data_in_20, data_in_21, data_in_22, data_in_23, data_in_24,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [2:0]            out_row,
    output logic [2:0]            out_col,
    output logic                  out_eol,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [DATA_WIDTH-1:0]   data_arr [25];
    logic [DATA_WIDTH-1:0]   snap     [25];
    logic [2:0]              row, col, r_lat, c_lat;
    logic                    err_q;
    logic                    dims_ok, capture, xfer, at_eol, at_last;
    logic [4:0]              sel;

    assign data_arr = '{data_in_0,  data_in_1,  data_in_2,  data_in_3,  data_in_4,
                        data_in_5,  data_in_6,  data_in_7,  data_in_8,  data_in_9,
                        data_in_10, data_in_11, data_in_12, data_in_13, data_in_14,
                        data_in_15, data_in_16, data_in_17, data_in_18, data_in_19,
                        data_in_20, data_in_21, data_in_22, data_in_23, data_in_24};

    assign dims_ok = (r_in != 3'd0) && (r_in <= 3'd5) && (c_in != 3'd0) && (c_in <= 3'd5);
    assign at_eol  = (col == c_lat - 3'd1);
    assign at_last = at_eol && (row == r_lat - 3'd1);
    assign xfer    = (state == SEND) && out_ready;
    assign sel     = 5'(row) * 5'd5 + 5'(col);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        out_data  = '0;
        out_row   = 3'd0;
        out_col   = 3'd0;
        out_eol   = 1'b0;
        out_last  = 1'b0;
        case (state)
            IDLE: begin
                // abort is meaningless here, so a simultaneous start still proceeds
                if (start && dims_ok) begin
                    state_nxt = SEND;
                    capture   = 1'b1;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = snap[sel];
                out_row   = row;
                out_col   = col;
                out_eol   = at_eol;
                out_last  = at_last;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (xfer && at_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign err = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
            row   <= 3'd0;
            col   <= 3'd0;
            r_lat <= 3'd0;
            c_lat <= 3'd0;
            for (int k = 0; k < 25; k++) begin
                snap[k] <= '0;
            end
        end else begin
            err_q <= (state == IDLE) && start && !dims_ok;
            if (capture) begin
                row   <= 3'd0;
                col   <= 3'd0;
                r_lat <= r_in;
                c_lat <= c_in;
                snap  <= data_arr;
            end else if (xfer) begin
                if (at_eol) begin
                    col <= 3'd0;
                    row <= row + 3'd1;
                end else begin
                    col <= col + 3'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_matrix_result_serializer.sv
// ============================================================================
//  Module   : tb_matrix_result_serializer
//  Brief    : Directed self-checking bench for matrix_result_serializer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matrix_result_serializer;

    localparam int DW = 9;

    logic          clk = 1'b0;
    logic          reset_n, start, abort, out_ready;
    logic [2:0]    r_in, c_in;
    logic [DW-1:0] din [25];
    logic          out_valid, out_eol, out_last, busy, done, err;
    logic [DW-1:0] out_data;
    logic [2:0]    out_row, out_col;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    matrix_result_serializer #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .r_in(r_in), .c_in(c_in),
        .data_in_0(din[0]),   .data_in_1(din[1]),   .data_in_2(din[2]),   .data_in_3(din[3]),
        .data_in_4(din[4]),   .data_in_5(din[5]),   .data_in_6(din[6]),   .data_in_7(din[7]),
        .data_in_8(din[8]),   .data_in_9(din[9]),   .data_in_10(din[10]), .data_in_11(din[11]),
        .data_in_12(din[12]), .data_in_13(din[13]), .data_in_14(din[14]), .data_in_15(din[15]),
        .data_in_16(din[16]), .data_in_17(din[17]), .data_in_18(din[18]), .data_in_19(din[19]),
        .data_in_20(din[20]), .data_in_21(din[21]), .data_in_22(din[22]), .data_in_23(din[23]),
        .data_in_24(din[24]),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_eol(out_eol), .out_last(out_last),
        .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_done"},  32'(done), 0);
        chk({tag, "_data"},  32'(out_data), 0);
        chk({tag, "_row"},   32'(out_row), 0);
        chk({tag, "_col"},   32'(out_col), 0);
    endtask

    // expected stream for the 2x3 case with data(i,j) = 10*i + j
    int seq23 [6] = '{0, 1, 2, 10, 11, 12};

    initial begin
        int idx, busy_cnt;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        r_in = 3'd0; c_in = 3'd0;
        for (int k = 0; k < 25; k++) din[k] = '0;
        #12;
        idle_outputs("reset");
        chk("reset_err", 32'(err), 0);
        reset_n = 1'b1;
        tick();

        // ---- 2x3 stream, ready always high
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) din[5*i+j] = DW'(10*i + j);
        r_in = 3'd2; c_in = 3'd3; out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            busy_cnt += int'(busy);
            chk("t1_valid", 32'(out_valid), 1);
            chk("t1_data",  32'(out_data), 32'(seq23[k]));
            chk("t1_row",   32'(out_row), 32'(k / 3));
            chk("t1_col",   32'(out_col), 32'(k % 3));
            chk("t1_eol",   32'(out_eol), 32'(k % 3 == 2));
            chk("t1_last",  32'(out_last), 32'(k == 5));
            tick();
        end
        busy_cnt += int'(busy);
        chk("t1_done", 32'(done), 1);
        chk("t1_done_valid", 32'(out_valid), 0);
        chk("t1_busy_cycles", 32'(busy_cnt), 6);
        tick();
        chk("t1_done_pulse", 32'(done), 0);

        // ---- same stream, ready pattern 1,0,0 repeating
        start = 1'b1;
        tick();
        start = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 40 && idx < 6; cyc++) begin
            out_ready = (cyc % 3 == 0);
            chk("t2_valid", 32'(out_valid), 1);
            chk("t2_data",  32'(out_data), 32'(seq23[idx]));
            chk("t2_col",   32'(out_col), 32'(idx % 3));
            tick();
            if (cyc % 3 == 0) idx++;
        end
        chk("t2_count", 32'(idx), 6);
        chk("t2_done", 32'(done), 1);
        out_ready = 1'b1;
        tick();

        // ---- bad dimensions
        r_in = 3'd0; c_in = 3'd3; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3a_err", 32'(err), 1);
        chk("t3a_busy", 32'(busy), 0);
        chk("t3a_valid", 32'(out_valid), 0);
        tick();
        chk("t3a_err_pulse", 32'(err), 0);
        chk("t3a_valid2", 32'(out_valid), 0);
        r_in = 3'd6; c_in = 3'd2; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3b_err", 32'(err), 1);
        chk("t3b_busy", 32'(busy), 0);
        chk("t3b_valid", 32'(out_valid), 0);
        tick();
        chk("t3b_err_pulse", 32'(err), 0);

        // ---- 5x5 with inputs overwritten after capture
        for (int k = 0; k < 25; k++) din[k] = DW'(7*k + 3);
        r_in = 3'd5; c_in = 3'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 25; k++) din[k] = 9'h1FF;
        r_in = 3'd1; c_in = 3'd1;
        for (int k = 0; k < 25; k++) begin
            chk("t4_valid", 32'(out_valid), 1);
            chk("t4_data",  32'(out_data), 32'(7*k + 3));
            chk("t4_row",   32'(out_row), 32'(k / 5));
            chk("t4_col",   32'(out_col), 32'(k % 5));
            chk("t4_last",  32'(out_last), 32'(k == 24));
            tick();
        end
        chk("t4_done", 32'(done), 1);
        tick();

        // ---- 3x3 aborted after four transfers, then restarted
        for (int k = 0; k < 25; k++) din[k] = DW'(100 + k);
        r_in = 3'd3; c_in = 3'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("t5_pre_row", 32'(out_row), 1);
        chk("t5_pre_col", 32'(out_col), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_valid", 32'(out_valid), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_done", 32'(done), 0);
        tick();
        chk("t5_done2", 32'(done), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_restart_valid", 32'(out_valid), 1);
        chk("t5_restart_data", 32'(out_data), 100);
        chk("t5_restart_row", 32'(out_row), 0);
        chk("t5_restart_col", 32'(out_col), 0);

        // ---- asynchronous reset mid-stream, then a 1x1 matrix
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        idle_outputs("t6_rst");
        #3;
        reset_n = 1'b1;
        tick();
        chk("t6_idle_valid", 32'(out_valid), 0);
        din[0] = 9'h155; r_in = 3'd1; c_in = 3'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_valid", 32'(out_valid), 1);
        chk("t6_data", 32'(out_data), 32'h155);
        chk("t6_eol", 32'(out_eol), 1);
        chk("t6_last", 32'(out_last), 1);
        tick();
        chk("t6_done", 32'(done), 1);
        chk("t6_done_valid", 32'(out_valid), 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
